// File: rtl/wide_add_pkg.sv
// Shared definitions for the limb-serial wide adder: default geometry and
// the sequencer state encoding.
package wide_add_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LIMBS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result bundle between producer, sequencer and consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never depends on ready, and payload is only meaningful while valid is 1.
interface wide_add_seq_if import wide_add_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMBS = DEF_LIMBS
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*LIMBS-1:0]   a;
    logic [WIDTH*LIMBS-1:0]   b;
    logic                     sub;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*LIMBS-1:0]   sum;
    logic                     cout;
    logic                     busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/adder_limb.sv
// One WIDTH-bit ripple-carry adder slice with carry in and carry out.
module adder_limb #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum    = w_full[WIDTH-1:0];
    assign cout   = w_full[WIDTH];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract: one shared limb adder walks the operands
// least-significant limb first, carrying between limbs in a register.
module wide_add_seq import wide_add_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMBS = DEF_LIMBS
) (
    input  logic  clk,
    input  logic  rst,
    wide_add_seq_if.slave bus,
    output state_t o_dbg_state
);

    localparam int OPW  = WIDTH * LIMBS;
    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LIMBS - 1);

    state_t          r_state;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [IDXW-1:0] r_idx;

    logic [WIDTH-1:0] w_a_limb;
    logic [WIDTH-1:0] w_b_limb;
    logic [WIDTH-1:0] w_s;
    logic             w_c;

    assign w_a_limb = r_a[int'(r_idx)*WIDTH +: WIDTH];
    assign w_b_limb = r_b[int'(r_idx)*WIDTH +: WIDTH];

    adder_limb #(.WIDTH(WIDTH)) u_limb (
        .a    (w_a_limb),
        .b    (w_b_limb),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    // Subtraction is a + ~b + 1: b is inverted at capture and the +1 enters as the first carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[int'(r_idx)*WIDTH +: WIDTH] <= w_s;
                    r_carry <= w_c;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_cout  <= w_c;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == RUN) || (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed arithmetic, back-pressure,
// mid-operation reset and streaming, with a queue-based result scoreboard.
module tb_wide_add_seq;
    import wide_add_pkg::*;

    localparam int WIDTH = 16;
    localparam int LIMBS = 4;
    localparam int OPW   = WIDTH * LIMBS;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     cyc;
    int     n_tests;
    int     n_fail;
    logic [OPW:0] exp_q[$];

    wide_add_seq_if #(.WIDTH(WIDTH), .LIMBS(LIMBS)) bus ();

    wide_add_seq #(.WIDTH(WIDTH), .LIMBS(LIMBS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [OPW:0] got, input logic [OPW:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [OPW:0] model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                           input logic s);
        logic [OPW:0] r;
        if (s) r = {(a >= b), a - b};
        else   r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Inputs change 1 time unit after the rising edge; results are scored on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1'b1, 1'b0);
            end else begin
                check("result", {bus.cout, bus.sum}, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic s, input int hold);
        logic [OPW:0] e;
        int n;
        int lat;
        e = model(a, b, s);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("wait_in_ready", 65'(n < 50), 65'(1));
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = s;
        exp_q.push_back(e);
        step();
        bus.in_valid = 1'b0;
        bus.a        = {$urandom(), $urandom()};
        bus.b        = {$urandom(), $urandom()};
        bus.sub      = ~s;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_run", 65'(bus.in_ready), 65'(0));
            check("busy_run", 65'(bus.busy), 65'(1));
            step();
            lat++;
        end
        check("latency", 65'(lat), 65'(LIMBS));
        for (int i = 0; i < hold; i++) begin
            check("hold_result", {bus.cout, bus.sum}, e);
            check("hold_in_ready", 65'(bus.in_ready), 65'(0));
            check("hold_out_valid", 65'(bus.out_valid), 65'(1));
            bus.in_valid = (i == 2);
            bus.a        = {$urandom(), $urandom()};
            bus.b        = {$urandom(), $urandom()};
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("post_out_valid", 65'(bus.out_valid), 65'(0));
        check("post_in_ready", 65'(bus.in_ready), 65'(1));
        step();
        check("no_second_result", 65'(bus.out_valid), 65'(0));
    endtask

    initial begin
        int acc[3];
        logic [OPW-1:0] sa[3];
        logic [OPW-1:0] sb[3];
        logic           ss[3];
        int n;

        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check("rst_in_ready", 65'(bus.in_ready), 65'(1));
        check("rst_out_valid", 65'(bus.out_valid), 65'(0));
        check("rst_busy", 65'(bus.busy), 65'(0));
        check("rst_sum_cout", {bus.cout, bus.sum}, 65'(0));
        check("rst_state", 65'(dbg_state), 65'(IDLE));

        // directed arithmetic
        do_op(64'd40000, 64'd6000, 1'b0, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        do_op(64'h0000_0001_0000_0000, 64'd1, 1'b1, 0);
        do_op(64'd0, 64'd1, 1'b1, 0);
        check("model_sub_borrow", model(64'd0, 64'd1, 1'b1), {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

        // back-pressure
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5);

        // reset after two RUN cycles
        bus.in_valid = 1'b1;
        bus.a        = 64'h0000_FFFF_0000_FFFF;
        bus.b        = 64'd7;
        bus.sub      = 1'b0;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", 65'(bus.in_ready), 65'(1));
        check("abort_sum", {bus.cout, bus.sum}, 65'(0));
        check("abort_busy", 65'(bus.busy), 65'(0));
        for (int i = 0; i < 6; i++) begin
            check("abort_no_out_valid", 65'(bus.out_valid), 65'(0));
            step();
        end
        do_op(64'd65535, 64'd1, 1'b0, 0);

        // random mix
        for (int i = 0; i < 4; i++) begin
            do_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                  (i == 1) ? $urandom_range(1, 3) : 0);
        end

        // streaming with in_valid held high
        for (int k = 0; k < 3; k++) begin
            sa[k] = {$urandom(), $urandom()};
            sb[k] = {$urandom(), $urandom()};
            ss[k] = k[0];
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a   = sa[k];
            bus.b   = sb[k];
            bus.sub = ss[k];
            exp_q.push_back(model(sa[k], sb[k], ss[k]));
            n = 0;
            while (!bus.in_ready && n < 50) begin
                step();
                n++;
            end
            check("stream_wait", 65'(n < 50), 65'(1));
            step();
            acc[k] = cyc;
        end
        bus.in_valid = 1'b0;
        check("stream_gap01", 65'(acc[1] - acc[0]), 65'(LIMBS + 2));
        check("stream_gap12", 65'(acc[2] - acc[1]), 65'(LIMBS + 2));
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        repeat (3) step();
        check("queue_drained", 65'(exp_q.size()), 65'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
